// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and constants for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int STAT_W     = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter; master is the arbiter's view.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = DEF_DATA_W
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic                        arb_en;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*DATA_W-1:0]   req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ-1:0]          grant;
  logic [IDX_W-1:0]            owner;
  logic                        busy;
  logic                        fifo_wr;
  logic [DATA_W-1:0]           fifo_din;
  logic                        fifo_full;

  modport master (
    input  arb_en, req_valid, req_data, fifo_full,
    output req_ready, grant, owner, busy, fifo_wr, fifo_din
  );

  modport slave (
    output arb_en, req_valid, req_data, fifo_full,
    input  req_ready, grant, owner, busy, fifo_wr, fifo_din
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] sel;
  logic          found;

  always_comb begin
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N; k++) begin
      sel = IW'((int'(ptr) + k) % N);
      if (!found && req[sel]) begin
        found     = 1'b1;
        pick[sel] = 1'b1;
        idx       = sel;
      end
    end
  end

  assign any = found;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-requester beat and stall counters are enabled with ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_wr_arbiter_if.master  bus
`ifdef ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_beats,
  output logic [STAT_W-1:0]         stat_stall
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [DATA_W-1:0]  data_arr [NUM_REQ];
  logic               in_burst;
  logic               owner_vld;
  logic               acc;
  logic               last_beat;
  logic [IDX_W-1:0]   next_ptr;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign data_arr[g] = bus.req_data[g*DATA_W +: DATA_W];
  end

  rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
    .req  (bus.req_valid),
    .ptr  (rr_ptr_q),
    .pick (pick_oh),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Transfers are blocked during the reset cycle so reset wins over a beat.
  assign in_burst  = (state_q == BURST);
  assign owner_vld = bus.req_valid[owner_q];
  assign acc       = rst_n && in_burst && owner_vld && !bus.fifo_full;
  assign last_beat = acc && ((beat_cnt_q + 1'b1) == CNT_W'(MAX_BURST));
  assign next_ptr  = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.arb_en && pick_any) begin
          state_d    = BURST;
          grant_d    = pick_oh;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (acc) beat_cnt_d = beat_cnt_q + 1'b1;
        // A full FIFO alone never ends the burst; only a limit, a drop or disable does.
        if (last_beat || !owner_vld || !bus.arb_en) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // grant_q is non-zero only in BURST, so it doubles as the ready mask.
  assign bus.req_ready = rst_n ? (grant_q & {NUM_REQ{~bus.fifo_full}}) : '0;
  assign bus.grant     = grant_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = in_burst;
  assign bus.fifo_wr   = acc;
  assign bus.fifo_din  = acc ? data_arr[owner_q] : '0;

`ifdef ARB_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [STAT_W-1:0] beats_q [NUM_REQ];
  logic [STAT_W-1:0] beats_d [NUM_REQ];
  logic [STAT_W-1:0] stall_q, stall_d;
  logic              stall_cond;

  assign stall_cond = rst_n && in_burst && owner_vld && bus.fifo_full;

  always_comb begin
    beats_d = beats_q;
    stall_d = stall_q;
    if (acc)        beats_d[owner_q] = sat_inc(beats_q[owner_q]);
    if (stall_cond) stall_d          = sat_inc(stall_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beats_q <= '{default: '0};
      stall_q <= '0;
    end else begin
      beats_q <= beats_d;
      stall_q <= stall_d;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_beats[g*STAT_W +: STAT_W] = beats_q[g];
  end
  assign stat_stall = stall_q;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares the single 8-bit synchronous FIFO write port among NUM_REQ producers.
- Grants one requester at a time for a bounded burst and forwards its data to FIFO wr/din.
- Gates every write with FIFO full, so the FIFO never sees a write while full.
- Sits directly in front of the FIFO; the read side is untouched.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, data width; must equal the FIFO data width
MAX_BURST, 4, maximum accepted beats per grant (1..15)

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
arb_en  input  1  arbitration enable; 0 = no new grants
req_valid  input  NUM_REQ  per-requester data valid
req_data  input  NUM_REQ*DATA_W  per-requester data; requester i at bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  per-requester accept; beat transfers when valid && ready
grant  output  NUM_REQ  registered one-hot current owner
owner  output  $clog2(NUM_REQ)  registered index of the owner
busy  output  1  1 while in BURST
fifo_wr  output  1  FIFO write strobe
fifo_din  output  DATA_W  FIFO write data
fifo_full  input  1  FIFO full flag

Behaviour:
- Reset is synchronous active-low; the cycle with rst_n==0 takes priority over all other events.
- Reset values: state=IDLE, grant=0, owner=0, busy=0, rr_ptr=0, beat_cnt=0, and hence req_ready=0, fifo_wr=0, fifo_din=0.
- FSM states are IDLE and BURST.
- IDLE:
  - If arb_en && |req_valid, pick the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register grant/owner for the pick, set beat_cnt=0, go to BURST.
  - Grant takes effect the next cycle: one bubble cycle per arbitration.
- BURST:
  - req_ready[owner] = !fifo_full; all other req_ready = 0.
  - fifo_wr = req_valid[owner] && !fifo_full (combinational).
  - fifo_din = req_data of owner when fifo_wr, else 0.
  - Each accepted beat increments beat_cnt.
- BURST -> IDLE on any of the following; the first matching item applies:
  - (a) accepted beat makes beat_cnt reach MAX_BURST.
  - (b) req_valid[owner]==0 in that cycle.
  - (c) arb_en==0; a beat accepted in that same cycle still completes.
- On exit: rr_ptr = owner+1 modulo NUM_REQ, grant=0, busy=0.
- fifo_full while in BURST: stall. The grant is held, beat_cnt is frozen, and there is no exit unless (b) or (c) applies.
- req_valid is sampled only for the owner; valid/data changes from non-owners are ignored.
- Latency: first beat at earliest 1 cycle after req_valid rises in IDLE; back-to-back beats thereafter.
- Fairness: after a grant to i, every other valid requester is served before i again.
- arb_en low in IDLE: stay IDLE, outputs 0.

Optional Feature:
Macro ARB_STATS_EN.
- Defined:
  - Adds output port stat_beats (NUM_REQ*16): per-requester count of accepted beats.
  - Adds output port stat_stall (16): count of BURST cycles with fifo_full && req_valid[owner].
  - All counters saturate at 16'hFFFF and clear on reset.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg: DATA_W default constant, state enum type (IDLE, BURST), STAT_W=16 constant.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot pick, index, any-valid.
  - Instantiated once in fifo_wr_arbiter.

Test Plan:
1. Reset mid-burst: req0 streaming, rst_n=0 for 1 cycle -> next cycle grant=0, fifo_wr=0, busy=0, rr_ptr=0; re-arbitration picks req0 again.
2. All four req_valid held high with 12 beats each, fifo_full=0 -> grants cycle 0,1,2,3,0… with 4 beats per grant and one bubble cycle between grants; all 48 bytes arrive in FIFO in grant order.
3. req2 alone, data 8'hA5, arb_en=1 -> grant[2] set the cycle after req_valid; fifo_wr=1, fifo_din=8'hA5 the same cycle.
4. Owner req1 gets fifo_full=1 after 2 beats for 5 cycles -> fifo_wr=0 and req_ready[1]=0 during the stall, grant held; the remaining 2 beats complete after full drops; never fifo_wr && fifo_full.
5. Owner req3 drops req_valid after 1 beat -> IDLE the next cycle; a pending req0 is granted next (wrap-around).
6. With ARB_STATS_EN, scenario 2 plus 3 stall cycles -> each stat_beats entry = 12, stat_stall = 3.
